// File: rtl/sim_run_controller_pkg.sv
// Shared types and helpers for the simulation run controller.
// Holds the run-state encoding, the error-count width and the fail rule.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2,
        STOPPED = 2'd3
    } run_state_t;

    localparam int ERR_W = 16;

    // A limit of zero means errors alone never fail the run.
    function automatic logic fail_eval(
        input logic             timeout,
        input logic [ERR_W-1:0] err_count,
        input logic [ERR_W-1:0] limit
    );
        return timeout || ((limit != '0) && (err_count >= limit));
    endfunction

endpackage

// File: rtl/sim_run_controller_if.sv
// Run-control bundle between the bench sequencer (master) and the run controller (slave).
// The master drives start/done/err and observes the status outputs.
interface sim_run_controller_if #(
    parameter int CNT_W = 32
);
    import sim_ctrl_pkg::*;

    logic             start;
    logic             done;
    logic             err;
    logic             stop;
    logic             running;
    logic             finished;
    logic             timeout;
    logic             fail;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, done, err,
        input  stop, running, finished, timeout, fail, err_count, cycle_count
    );

    modport slave (
        input  start, done, err,
        output stop, running, finished, timeout, fail, err_count, cycle_count
    );

endinterface

// File: rtl/sim_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller: counts RUN cycles, drains after done, then raises stop to halt the test clock.
// Reset is asynchronous because the clock is halted while stop is high.
//
// state   | meaning
// IDLE    | waiting for start; done/err ignored
// RUN     | counting cycles until done or MAX_CYCLES elapse
// DRAIN   | fixed DRAIN_CYCLES settle period after done
// STOPPED | stop/finished high, all outputs frozen until reset
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES   = 10000,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32,
    parameter int ERR_LIMIT    = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    sim_run_controller_if.slave bus
);

    localparam int DRAIN_LOAD_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int DW           = (DRAIN_LOAD_I > 0) ? $clog2(DRAIN_LOAD_I + 1) : 1;
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_LOAD_I);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
    localparam logic [ERR_W-1:0] LIMIT      = ERR_W'(ERR_LIMIT);

    run_state_t       state;
    logic [CNT_W-1:0] cycle_count_q;
    logic [DW-1:0]    drain_q;
    logic             stop_q;
    logic             running_q;
    logic             finished_q;
    logic             timeout_q;
    logic             fail_q;
    logic [ERR_W-1:0] err_count_q;
    logic             err_clear;
    logic             err_inc;
    logic [ERR_W-1:0] err_next;

    assign err_clear = (state == IDLE) && bus.start;
    assign err_inc   = bus.err && ((state == RUN) || (state == DRAIN));

    // Value err_count takes on this edge, so fail sees the error sampled on the stop edge too.
    assign err_next = (err_inc && (err_count_q != '1)) ? err_count_q + ERR_W'(1) : err_count_q;

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (err_clear),
        .inc   (err_inc),
        .q     (err_count_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cycle_count_q <= '0;
            drain_q       <= '0;
            stop_q        <= 1'b0;
            running_q     <= 1'b0;
            finished_q    <= 1'b0;
            timeout_q     <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= RUN;
                        cycle_count_q <= '0;
                        running_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.done) begin
                        if (DRAIN_CYCLES == 0) begin
                            state      <= STOPPED;
                            stop_q     <= 1'b1;
                            finished_q <= 1'b1;
                            running_q  <= 1'b0;
                            fail_q     <= fail_eval(1'b0, err_next, LIMIT);
                        end else begin
                            state   <= DRAIN;
                            drain_q <= DRAIN_LOAD;
                        end
                    end else if (cycle_count_q == LAST_CYCLE) begin
                        state      <= STOPPED;
                        stop_q     <= 1'b1;
                        finished_q <= 1'b1;
                        running_q  <= 1'b0;
                        timeout_q  <= 1'b1;
                        fail_q     <= fail_eval(1'b1, err_next, LIMIT);
                    end else begin
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state      <= STOPPED;
                        stop_q     <= 1'b1;
                        finished_q <= 1'b1;
                        running_q  <= 1'b0;
                        fail_q     <= fail_eval(1'b0, err_next, LIMIT);
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                STOPPED: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stop        = stop_q;
    assign bus.running     = running_q;
    assign bus.finished    = finished_q;
    assign bus.timeout     = timeout_q;
    assign bus.fail        = fail_q;
    assign bus.err_count   = err_count_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Self-checking bench: three controller configurations driven by directed and random runs,
// each compared against a run-level model (cycle budgets, error tallies, fail rule).
module tb_sim_run_controller;

    function automatic int max_of(input int g);
        case (g)
            0:       return 100;
            1:       return 50;
            default: return 20;
        endcase
    endfunction

    function automatic int drn_of(input int g);
        case (g)
            0:       return 4;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int lim_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            default: return 0;
        endcase
    endfunction

    logic        clk;
    logic [2:0]  rst_n_v;
    logic [2:0]  start_v;
    logic [2:0]  done_v;
    logic [2:0]  err_v;
    logic [2:0]  stop_v;
    logic [2:0]  running_v;
    logic [2:0]  finished_v;
    logic [2:0]  timeout_v;
    logic [2:0]  fail_v;
    logic [15:0] ec_v [3];
    logic [31:0] cc_v [3];

    logic        sc_rst_n;
    logic        sc_clear;
    logic        sc_inc;
    logic [2:0]  sc_q;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sim_run_controller_if #(.CNT_W(32)) bus ();

        assign bus.start     = start_v[g];
        assign bus.done      = done_v[g];
        assign bus.err       = err_v[g];
        assign stop_v[g]     = bus.stop;
        assign running_v[g]  = bus.running;
        assign finished_v[g] = bus.finished;
        assign timeout_v[g]  = bus.timeout;
        assign fail_v[g]     = bus.fail;
        assign ec_v[g]       = bus.err_count;
        assign cc_v[g]       = bus.cycle_count;

        sim_run_controller #(
            .MAX_CYCLES   (max_of(g)),
            .DRAIN_CYCLES (drn_of(g)),
            .CNT_W        (32),
            .ERR_LIMIT    (lim_of(g))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n_v[g]),
            .bus   (bus)
        );
    end

    sat_counter #(.W(3)) u_sc (
        .clk   (clk),
        .rst_n (sc_rst_n),
        .clear (sc_clear),
        .inc   (sc_inc),
        .q     (sc_q)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input int i, input string tag);
        chk($sformatf("%0d:%s", i, tag),
            {stop_v[i], running_v[i], finished_v[i], timeout_v[i], fail_v[i], ec_v[i], cc_v[i]}, '0);
    endtask

    // Asynchronous reset applied mid-low-phase so no clock edge separates assert and check.
    task automatic do_reset(input int i);
        @(negedge clk);
        #2;
        rst_n_v[i] = 1'b0;
        #1;
        chk_all_zero(i, "async_reset");
        start_v[i] = 1'b0;
        done_v[i]  = 1'b0;
        err_v[i]   = 1'b0;
        @(negedge clk);
        rst_n_v[i] = 1'b1;
    endtask

    // One complete run: pre idle cycles, start, done after done_at RUN cycles (-1: never),
    // errors at random (pct) plus forced RUN cycles ea/eb and DRAIN cycle ed.
    task automatic run_case(input int i, input int pre, input int done_at, input int pct,
                            input int ea, input int eb, input int ed);
        int  exp_err = 0;
        int  r = 0;
        bit  to = 1'b0;
        bit  e;
        bit  exp_fail;
        int  lim = lim_of(i);
        int  mx  = max_of(i);
        logic [63:0] snap;

        for (int k = 0; k <= pre; k++) begin
            @(negedge clk);
            chk($sformatf("%0d:idle_running", i), running_v[i], 1'b0);
            start_v[i] = (k == pre);
            done_v[i]  = 1'($urandom);
            err_v[i]   = 1'($urandom);
        end

        forever begin
            @(negedge clk);
            chk($sformatf("%0d:run_running", i), running_v[i], 1'b1);
            chk($sformatf("%0d:run_cc", i), cc_v[i], 64'(r));
            start_v[i] = 1'($urandom);
            done_v[i]  = (r == done_at);
            e = (int'($urandom_range(99)) < pct) || (r == ea) || (r == eb);
            err_v[i] = e;
            if (e) exp_err++;
            if (r == done_at) begin
                to = 1'b0;
                break;
            end
            if (r == mx - 1) begin
                to = 1'b1;
                break;
            end
            r++;
        end

        if (!to) begin
            for (int j = 0; j < drn_of(i); j++) begin
                @(negedge clk);
                chk($sformatf("%0d:drain_state", i), {running_v[i], finished_v[i], stop_v[i]}, 3'b100);
                chk($sformatf("%0d:drain_cc", i), cc_v[i], 64'(r));
                start_v[i] = 1'($urandom);
                done_v[i]  = 1'($urandom);
                e = (int'($urandom_range(99)) < pct) || (j == ed);
                err_v[i] = e;
                if (e) exp_err++;
            end
        end

        if (exp_err > 65535) exp_err = 65535;
        exp_fail = to || ((lim != 0) && (exp_err >= lim));

        @(negedge clk);
        chk($sformatf("%0d:stop_state", i), {stop_v[i], finished_v[i], running_v[i]}, 3'b110);
        chk($sformatf("%0d:timeout", i), timeout_v[i], to);
        chk($sformatf("%0d:fail", i), fail_v[i], exp_fail);
        chk($sformatf("%0d:err_count", i), ec_v[i], 64'(exp_err));
        chk($sformatf("%0d:final_cc", i), cc_v[i], 64'(r));

        snap = {stop_v[i], finished_v[i], running_v[i], timeout_v[i], fail_v[i], ec_v[i], cc_v[i]};
        repeat (3) begin
            start_v[i] = 1'($urandom);
            done_v[i]  = 1'($urandom);
            err_v[i]   = 1'($urandom);
            @(negedge clk);
            chk($sformatf("%0d:frozen", i),
                {stop_v[i], finished_v[i], running_v[i], timeout_v[i], fail_v[i], ec_v[i], cc_v[i]}, snap);
        end

        do_reset(i);
    endtask

    initial begin
        int inst;
        int dat;

        rst_n_v  = 3'b000;
        start_v  = 3'b000;
        done_v   = 3'b000;
        err_v    = 3'b000;
        sc_rst_n = 1'b0;
        sc_clear = 1'b0;
        sc_inc   = 1'b0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_all_zero(i, "reset_state");
        chk("sc:reset", sc_q, 3'd0);
        rst_n_v  = 3'b111;
        sc_rst_n = 1'b1;

        // Normal run, done after 20 RUN cycles, four drain cycles.
        run_case(0, 2, 20, 0, -1, -1, -1);
        // Timeout with no done.
        run_case(1, 1, -1, 0, -1, -1, -1);
        // done on the last budgeted cycle wins over timeout.
        run_case(1, 0, 49, 0, -1, -1, -1);
        // Two errors in RUN plus one in DRAIN reaches the limit; two alone does not.
        run_case(0, 1, 10, 0, 3, 7, 1);
        run_case(0, 1, 10, 0, 3, 7, -1);

        // Reset in the middle of DRAIN, then a fresh run from zero.
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            done_v[0]  = (r == 10);
        end
        @(negedge clk);
        done_v[0] = 1'b0;
        chk("0:mid_drain_running", running_v[0], 1'b1);
        do_reset(0);
        run_case(0, 0, 7, 30, -1, -1, -1);

        // Zero drain: idle noise ignored, done 5 cycles in stops on the next edge.
        run_case(2, 3, 5, 0, -1, -1, -1);

        // Random runs across all configurations.
        for (int n = 0; n < 12; n++) begin
            inst = int'($urandom_range(2));
            case ($urandom_range(3))
                0:       dat = -1;
                1:       dat = max_of(inst) - 1;
                default: dat = int'($urandom_range(max_of(inst) - 1));
            endcase
            run_case(inst, int'($urandom_range(4)), dat, int'($urandom_range(60)), -1, -1, -1);
        end

        // Saturating counter standalone: counts, holds at all-ones, clears.
        @(negedge clk);
        sc_clear = 1'b1;
        @(negedge clk);
        sc_clear = 1'b0;
        sc_inc   = 1'b1;
        repeat (3) @(negedge clk);
        chk("sc:count3", sc_q, 3'd3);
        repeat (7) @(negedge clk);
        chk("sc:saturate", sc_q, 3'd7);
        sc_inc   = 1'b0;
        sc_clear = 1'b1;
        @(negedge clk);
        chk("sc:clear", sc_q, 3'd0);
        sc_clear = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
